ahblite_interconnect: RTL and testbench
=======================================

Name: ahblite_interconnect

Overview:
- Parametrised next-generation AHB-Lite single-master decoder plus slave-response multiplexer for the SoC bus.
- Decodes HADDR against NUM_PORTS programmable base/mask windows and drives one-hot HSEL.
- Registers the selection for the data phase and muxes slave HRDATA/HREADYOUT/HRESP back to the master.
- Contains a built-in default slave that gives a spec-compliant two-cycle ERROR for unmapped accesses.

Parameters:
- NUM_PORTS, 6, number of slave ports (1..16).
- PORT_BASE, {0x40300000,0x40100000,0x40000010,0x40050000,0x20000000,0x00000000}, flattened 32*NUM_PORTS bit vector; port i uses bits [32i+31:32i].
- PORT_MASK, {0xFFF00000,0xFFF00000,0xFFFFFFF0,0xFFFF0000,0xFFFF0000,0xFFFF0000}, flattened 32*NUM_PORTS bit vector; port i matches when (HADDR & mask_i) == (base_i & mask_i).
- PORT_EN, all ones, NUM_PORTS bit vector; a 0 bit makes that window never match.
- TIMEOUT_CYCLES, 1024, wait-state limit (only used with AHB_TIMEOUT_EN); minimum 2.

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  asynchronous active-low reset.
- HADDR  in  32  master address-phase address.
- HTRANS  in  2  master transfer type.
- HSEL  out  NUM_PORTS  one-hot address-phase slave select, combinational from HADDR.
- HREADYOUT_S  in  NUM_PORTS  per-slave HREADYOUT.
- HRESP_S  in  NUM_PORTS  per-slave HRESP.
- HRDATA_S  in  32*NUM_PORTS  per-slave read data, flattened.
- HREADY  out  1  muxed ready, routed to the master and to all slaves.
- HRESP  out  1  muxed response.
- HRDATA  out  32  muxed read data.
- DECERR  out  1  one-cycle pulse on the first cycle of any block-generated ERROR response.

Behaviour:
- Decode (combinational):
  - match_i = PORT_EN[i] & ((HADDR & mask_i) == (base_i & mask_i)).
  - On overlapping windows the lowest index wins, so HSEL is always one-hot or zero.
  - HSEL is independent of HTRANS; slaves qualify with HTRANS.
  - No match means the default slave is selected.
- Data-phase select register (dsel, NUM_PORTS+1 one-hot incl. default):
  - Loads the decode result on a rising HCLK edge when HREADY=1; holds otherwise.
  - Reset value: default slave selected.
- Output mux:
  - When dsel selects port i: HREADY=HREADYOUT_S[i], HRESP=HRESP_S[i], HRDATA=HRDATA_S[i].
  - When the default slave is selected: HRDATA=0.
- Default slave FSM, states D_IDLE, D_ERR1, D_ERR2; reset to D_IDLE:
  - D_IDLE: outputs HREADY=1, HRESP=0. If HREADY=1, HTRANS[1]=1 (NONSEQ/SEQ) and nothing matched, go to D_ERR1.
  - D_ERR1: outputs HREADY=0, HRESP=1, DECERR=1. Always go to D_ERR2.
  - D_ERR2: outputs HREADY=1, HRESP=1. Next state is D_ERR1 if another unmapped active transfer is presented, else D_IDLE.
  - IDLE or BUSY transfers to unmapped addresses get a zero-wait OKAY.
- Reset values:
  - HREADY=1, HRESP=0, HRDATA=0, DECERR=0.
  - HSEL follows HADDR combinationally.
- Reset asserted mid-transfer (including mid-ERROR):
  - All state returns immediately to reset values.
  - No partial response is completed after release.
- Back-to-back transfers:
  - The address phase of transfer N+1 overlaps the data phase of N.
  - dsel must not change while HREADY=0.

Optional Feature:
- Macro: AHB_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter increments each cycle while a real port is selected in the data phase and its HREADYOUT_S=0.
  - The counter clears whenever HREADY=1.
  - When the count reaches TIMEOUT_CYCLES-1, the block overrides the mux: it drives HREADY=0, HRESP=1 and DECERR=1 for one cycle, then HREADY=1, HRESP=1 for one cycle.
  - During the override, the stalled slave's outputs are ignored. dsel then reloads normally.
  - The counter saturates and never wraps.
- Without the macro: no counter and no override logic; a stalled slave stalls the bus indefinitely.

Test Plan:
1. Read HADDR=0x20000004, NONSEQ, port1 HRDATA_S=0xDEADBEEF, zero wait -> HSEL=0b000010 in the address phase; next cycle HRDATA=0xDEADBEEF, HRESP=0.
2. Port0 inserts 3 wait states while the next address 0x40050000 is presented -> dsel stays on port0 for all 4 cycles, HREADY=0 for 3 cycles; HSEL=0b000100 is held; port2 data phase starts after HREADY=1.
3. NONSEQ to unmapped 0x60000000 -> cycle1 HREADY=0/HRESP=1/DECERR=1, cycle2 HREADY=1/HRESP=1, then OKAY; the same address with HTRANS=IDLE -> zero-wait OKAY.
4. Override PORT_MASK so ports 3 and 4 both match 0x40000010 -> HSEL=0b001000 (lowest index wins); with PORT_EN[3]=0 -> HSEL=0b010000.
5. HRESETn asserted during D_ERR1 -> HREADY=1, HRESP=0, DECERR=0 the same cycle; after release the first access to 0x00000000 selects port0.
6. AHB_TIMEOUT_EN, TIMEOUT_CYCLES=8, port5 holds HREADYOUT_S=0 -> after 7 wait cycles a two-cycle ERROR with a DECERR pulse; a subsequent port0 access completes normally.

Source files
------------

// File: rtl/ahblite_interconnect.sv
// AHB-Lite single-master decoder and response mux with an ERROR default slave; AHB_TIMEOUT_EN adds a wait-state watchdog.
// Latency: HSEL is combinational from HADDR; the response mux follows a data-phase select registered while HREADY=1.
// Backpressure: HREADY mirrors the data-phase slave; unmapped active transfers get a two-cycle ERROR (one wait state).
module ahblite_interconnect #(
  parameter int NUM_PORTS = 6,
  parameter logic [32*NUM_PORTS-1:0] PORT_BASE = {32'h4030_0000, 32'h4010_0000, 32'h4000_0010,
                                                 32'h4005_0000, 32'h2000_0000, 32'h0000_0000},
  parameter logic [32*NUM_PORTS-1:0] PORT_MASK = {32'hFFF0_0000, 32'hFFF0_0000, 32'hFFFF_FFF0,
                                                 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000},
  parameter logic [NUM_PORTS-1:0] PORT_EN = {NUM_PORTS{1'b1}},
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [31:0]             HADDR,
  input  logic [1:0]              HTRANS,
  output logic [NUM_PORTS-1:0]    HSEL,
  input  logic [NUM_PORTS-1:0]    HREADYOUT_S,
  input  logic [NUM_PORTS-1:0]    HRESP_S,
  input  logic [32*NUM_PORTS-1:0] HRDATA_S,
  output logic                    HREADY,
  output logic                    HRESP,
  output logic [31:0]             HRDATA,
  output logic                    DECERR
);

  localparam int DEF = NUM_PORTS;

  typedef enum logic [1:0] {D_IDLE, D_ERR1, D_ERR2} dstate_t;

  logic [NUM_PORTS-1:0] match;
  logic [NUM_PORTS-1:0] hsel_c;
  logic                 hit;
  logic [NUM_PORTS:0]   dsel;
  logic                 ready_m;
  logic                 resp_m;
  logic [31:0]          rdata_m;
  dstate_t              dstate;
  logic                 def_ready;
  logic                 def_resp;
  logic                 def_decerr;
  logic                 unmapped_active;
  logic                 unused_htrans0;

  assign unused_htrans0 = HTRANS[0];

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      match[i] = PORT_EN[i] &
                 ((HADDR & PORT_MASK[32*i +: 32]) == (PORT_BASE[32*i +: 32] & PORT_MASK[32*i +: 32]));
    end
  end

  // Isolating the lowest set bit gives lowest-index priority on overlapping windows.
  assign hsel_c = match & (-match);
  assign hit    = |match;
  assign HSEL   = hsel_c;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel <= {1'b1, {NUM_PORTS{1'b0}}};
    end else if (HREADY) begin
      dsel <= {~hit, hsel_c};
    end
  end

  always_comb begin
    ready_m = dsel[DEF] & def_ready;
    resp_m  = dsel[DEF] & def_resp;
    rdata_m = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      ready_m = ready_m | (dsel[i] & HREADYOUT_S[i]);
      resp_m  = resp_m  | (dsel[i] & HRESP_S[i]);
      rdata_m = rdata_m | (HRDATA_S[32*i +: 32] & {32{dsel[i]}});
    end
  end

  assign unmapped_active = HREADY & HTRANS[1] & ~hit;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dstate     <= D_IDLE;
      def_ready  <= 1'b1;
      def_resp   <= 1'b0;
      def_decerr <= 1'b0;
    end else begin
      case (dstate)
        D_IDLE, D_ERR2: begin
          if (unmapped_active) begin
            dstate     <= D_ERR1;
            def_ready  <= 1'b0;
            def_resp   <= 1'b1;
            def_decerr <= 1'b1;
          end else begin
            dstate     <= D_IDLE;
            def_ready  <= 1'b1;
            def_resp   <= 1'b0;
            def_decerr <= 1'b0;
          end
        end
        D_ERR1: begin
          dstate     <= D_ERR2;
          def_ready  <= 1'b1;
          def_resp   <= 1'b1;
          def_decerr <= 1'b0;
        end
        default: begin
          dstate     <= D_IDLE;
          def_ready  <= 1'b1;
          def_resp   <= 1'b0;
          def_decerr <= 1'b0;
        end
      endcase
    end
  end

`ifdef AHB_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] to_cnt;
  logic        to_err1;
  logic        to_err2;

  assign to_err1 = ~dsel[DEF] & ~to_err2 & (to_cnt == TO_LIMIT);

  // Counts stalled data-phase cycles of a real port; HREADY=1 ends the stall.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      to_cnt  <= '0;
      to_err2 <= 1'b0;
    end else begin
      to_err2 <= to_err1;
      if (HREADY) begin
        to_cnt <= '0;
      end else if (!dsel[DEF] && to_cnt != 16'hFFFF) begin
        to_cnt <= to_cnt + 16'd1;
      end
    end
  end

  assign HREADY = to_err1 ? 1'b0 : (to_err2 | ready_m);
  assign HRESP  = to_err1 | to_err2 | resp_m;
  assign DECERR = to_err1 | def_decerr;
`else
  logic [15:0] unused_to_limit;
  assign unused_to_limit = 16'(TIMEOUT_CYCLES - 1);

  assign HREADY = ready_m;
  assign HRESP  = resp_m;
  assign DECERR = def_decerr;
`endif

  assign HRDATA = rdata_m;

endmodule

// File: tb/tb_ahblite_interconnect.sv
// Directed bench for ahblite_interconnect: a transfer-level model is compared against the DUT every cycle.
`timescale 1ns/1ps
module tb_ahblite_interconnect;

  localparam int NP = 6;
  localparam int TO = 8;
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [32*NP-1:0] OVL_MASK = {32'hFFF0_0000, 32'hFF00_0000, 32'hFFFF_FFF0,
                                           32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};

  logic            HCLK = 1'b0;
  logic            HRESETn;
  logic [31:0]     haddr;
  logic [1:0]      htrans;
  logic [NP-1:0]   hreadyout_s;
  logic [NP-1:0]   hresp_s;
  logic [32*NP-1:0] hrdata_s;
  logic [NP-1:0]   hsel, hsel_ovl, hsel_dis;
  logic            hready, hresp, decerr;
  logic [31:0]     hrdata;
  logic            unused_ovl_rdy, unused_ovl_resp, unused_ovl_derr;
  logic            unused_dis_rdy, unused_dis_resp, unused_dis_derr;
  logic [31:0]     unused_ovl_rdata, unused_dis_rdata;

  int total = 0;
  int bad   = 0;

  always #5 HCLK = ~HCLK;

  ahblite_interconnect #(.NUM_PORTS(NP), .TIMEOUT_CYCLES(TO)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(haddr), .HTRANS(htrans), .HSEL(hsel),
    .HREADYOUT_S(hreadyout_s), .HRESP_S(hresp_s), .HRDATA_S(hrdata_s),
    .HREADY(hready), .HRESP(hresp), .HRDATA(hrdata), .DECERR(decerr));

  ahblite_interconnect #(.NUM_PORTS(NP), .PORT_MASK(OVL_MASK)) u_ovl (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(haddr), .HTRANS(htrans), .HSEL(hsel_ovl),
    .HREADYOUT_S(hreadyout_s), .HRESP_S(hresp_s), .HRDATA_S(hrdata_s),
    .HREADY(unused_ovl_rdy), .HRESP(unused_ovl_resp), .HRDATA(unused_ovl_rdata), .DECERR(unused_ovl_derr));

  ahblite_interconnect #(.NUM_PORTS(NP), .PORT_MASK(OVL_MASK), .PORT_EN(6'b110111)) u_dis (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(haddr), .HTRANS(htrans), .HSEL(hsel_dis),
    .HREADYOUT_S(hreadyout_s), .HRESP_S(hresp_s), .HRDATA_S(hrdata_s),
    .HREADY(unused_dis_rdy), .HRESP(unused_dis_resp), .HRDATA(unused_dis_rdata), .DECERR(unused_dis_derr));

  // Address windows of the three instances, written out per port.
  logic [31:0]   win_base [3][NP];
  logic [31:0]   win_mask [3][NP];
  logic [NP-1:0] win_en   [3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      win_base[k][0] = 32'h0000_0000; win_mask[k][0] = 32'hFFFF_0000;
      win_base[k][1] = 32'h2000_0000; win_mask[k][1] = 32'hFFFF_0000;
      win_base[k][2] = 32'h4005_0000; win_mask[k][2] = 32'hFFFF_0000;
      win_base[k][3] = 32'h4000_0010; win_mask[k][3] = 32'hFFFF_FFF0;
      win_base[k][4] = 32'h4010_0000; win_mask[k][4] = (k == 0) ? 32'hFFF0_0000 : 32'hFF00_0000;
      win_base[k][5] = 32'h4030_0000; win_mask[k][5] = 32'hFFF0_0000;
      win_en[k]      = (k == 2) ? 6'b110111 : 6'b111111;
    end
  end

  function automatic int decode(input int k, input logic [31:0] a);
    for (int i = 0; i < NP; i++)
      if (win_en[k][i] && ((a & win_mask[k][i]) == (win_base[k][i] & win_mask[k][i]))) return i;
    return -1;
  endfunction

  function automatic logic [NP-1:0] exp_hsel(input int k);
    logic [NP-1:0] v;
    int idx;
    v = '0;
    idx = decode(k, haddr);
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  // Transaction-level state: who owns the data phase, and how far along an ERROR response is.
  typedef struct packed { int owner; int err; int to; int cnt; } mstate_t;
  typedef struct packed { logic r; logic rs; logic de; logic chk; logic [31:0] rd; } exp_t;

  mstate_t m;

  function automatic exp_t expect_now();
    exp_t e;
    e = '{r: 1'b1, rs: 1'b0, de: 1'b0, chk: 1'b1, rd: 32'h0};
    if (m.to == 2) begin
      e.r = 1'b0; e.rs = 1'b1; e.de = 1'b1; e.chk = 1'b0;
    end else if (m.to == 1) begin
      e.rs = 1'b1; e.chk = 1'b0;
    end else if (m.owner >= 0) begin
      e.r  = hreadyout_s[m.owner];
      e.rs = hresp_s[m.owner];
      e.rd = hrdata_s[32*m.owner +: 32];
    end else if (m.err == 2) begin
      e.r = 1'b0; e.rs = 1'b1; e.de = 1'b1;
    end else if (m.err == 1) begin
      e.rs = 1'b1;
    end
    return e;
  endfunction

  function automatic mstate_t model_next();
    mstate_t ns;
    exp_t e;
    int nxt;
    ns = m;
    e = expect_now();
    if (e.r) begin
      nxt = decode(0, haddr);
      ns.owner = nxt;
      ns.err = (nxt < 0 && htrans[1]) ? 2 : 0;
      ns.to = 0;
      ns.cnt = 0;
    end else begin
      if (ns.err == 2) ns.err = 1;
`ifdef AHB_TIMEOUT_EN
      if (ns.to == 2) ns.to = 1;
      else if (ns.owner >= 0) begin
        ns.cnt = ns.cnt + 1;
        if (ns.cnt == TO - 1) ns.to = 2;
      end
`endif
    end
    return ns;
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) m <= '{owner: -1, err: 0, to: 0, cnt: 0};
    else          m <= model_next();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    exp_t e;
    e = expect_now();
    check("m_hsel", 32'(hsel), 32'(exp_hsel(0)));
    check("m_hsel_ovl", 32'(hsel_ovl), 32'(exp_hsel(1)));
    check("m_hsel_dis", 32'(hsel_dis), 32'(exp_hsel(2)));
    check("m_hready", 32'(hready), 32'(e.r));
    check("m_hresp", 32'(hresp), 32'(e.rs));
    check("m_decerr", 32'(decerr), 32'(e.de));
    if (e.chk) check("m_hrdata", hrdata, e.rd);
  endtask

  always @(negedge HCLK) compare_all();

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n;
    logic seen;
    HRESETn = 1'b0; haddr = '0; htrans = IDLE;
    hreadyout_s = '1; hresp_s = '0;
    hrdata_s = {32'h5555_0005, 32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'hDEAD_BEEF, 32'h1111_0000};
    repeat (2) @(negedge HCLK);
    check("rst_hready", 32'(hready), 32'd1);
    check("rst_hresp", 32'(hresp), 32'd0);
    check("rst_hrdata", hrdata, 32'h0);
    check("rst_decerr", 32'(decerr), 32'd0);

    // 1: zero-wait read from port1
    tick(); HRESETn = 1'b1; haddr = 32'h2000_0004; htrans = NONSEQ;
    @(negedge HCLK); check("t1_hsel", 32'(hsel), 32'b000010);
    tick(); haddr = 32'h0; htrans = IDLE;
    @(negedge HCLK);
    check("t1_hrdata", hrdata, 32'hDEAD_BEEF);
    check("t1_hresp", 32'(hresp), 32'd0);
    check("t1_hready", 32'(hready), 32'd1);

    // 2: port0 with three wait states, next address held on port2
    tick(); haddr = 32'h0; htrans = NONSEQ;
    tick(); haddr = 32'h4005_0000; hreadyout_s[0] = 1'b0;
    @(negedge HCLK);
    check("t2_w1_ready", 32'(hready), 32'd0);
    check("t2_hsel", 32'(hsel), 32'b000100);
    check("t2_w1_rdata", hrdata, 32'h1111_0000);
    tick(); @(negedge HCLK); check("t2_w2_ready", 32'(hready), 32'd0);
    tick(); @(negedge HCLK); check("t2_w3_ready", 32'(hready), 32'd0);
    check("t2_w3_hsel", 32'(hsel), 32'b000100);
    tick(); hreadyout_s[0] = 1'b1;
    @(negedge HCLK); check("t2_done_ready", 32'(hready), 32'd1);
    tick(); haddr = 32'h0; htrans = IDLE;
    @(negedge HCLK); check("t2_p2_rdata", hrdata, 32'h2222_0002);

    // 3: unmapped NONSEQ gets two-cycle ERROR, unmapped IDLE gets OKAY
    tick(); haddr = 32'h6000_0000; htrans = NONSEQ;
    @(negedge HCLK); check("t3_hsel", 32'(hsel), 32'b0);
    tick(); htrans = IDLE;
    @(negedge HCLK);
    check("t3_e1_ready", 32'(hready), 32'd0);
    check("t3_e1_resp", 32'(hresp), 32'd1);
    check("t3_e1_decerr", 32'(decerr), 32'd1);
    tick(); @(negedge HCLK);
    check("t3_e2_ready", 32'(hready), 32'd1);
    check("t3_e2_resp", 32'(hresp), 32'd1);
    check("t3_e2_decerr", 32'(decerr), 32'd0);
    tick(); @(negedge HCLK);
    check("t3_idle_ready", 32'(hready), 32'd1);
    check("t3_idle_resp", 32'(hresp), 32'd0);

    // 4: overlapping windows, lowest index wins unless disabled
    tick(); haddr = 32'h4000_0010; htrans = IDLE;
    @(negedge HCLK);
    check("t4_hsel", 32'(hsel), 32'b001000);
    check("t4_ovl_hsel", 32'(hsel_ovl), 32'b001000);
    check("t4_dis_hsel", 32'(hsel_dis), 32'b010000);

    // 5: reset during the first ERROR cycle
    tick(); haddr = 32'h7000_0000; htrans = NONSEQ;
    tick(); #1;
    check("t5_pre_decerr", 32'(decerr), 32'd1);
    HRESETn = 1'b0; #1;
    check("t5_rst_ready", 32'(hready), 32'd1);
    check("t5_rst_resp", 32'(hresp), 32'd0);
    check("t5_rst_decerr", 32'(decerr), 32'd0);
    @(negedge HCLK);
    tick(); HRESETn = 1'b1; haddr = 32'h0; htrans = NONSEQ;
    @(negedge HCLK); check("t5_hsel", 32'(hsel), 32'b000001);
    tick(); htrans = IDLE;
    @(negedge HCLK);
    check("t5_rdata", hrdata, 32'h1111_0000);
    check("t5_resp", 32'(hresp), 32'd0);

    // 6: port5 never becomes ready
    tick(); haddr = 32'h4030_0000; htrans = NONSEQ;
    @(negedge HCLK); check("t6_hsel", 32'(hsel), 32'b100000);
    tick(); haddr = 32'h0; htrans = NONSEQ; hreadyout_s[5] = 1'b0;
    n = 0;
    seen = 1'b0;
`ifdef AHB_TIMEOUT_EN
    repeat (40) begin
      if (!seen) begin
        @(negedge HCLK);
        if (decerr) seen = 1'b1;
        else begin
          if (!hready) n++;
          tick();
        end
      end
    end
    check("t6_to_seen", 32'(seen), 32'd1);
    check("t6_to_waits", n, TO - 1);
    check("t6_e1_ready", 32'(hready), 32'd0);
    check("t6_e1_resp", 32'(hresp), 32'd1);
    tick(); hreadyout_s[5] = 1'b1;
    @(negedge HCLK);
    check("t6_e2_ready", 32'(hready), 32'd1);
    check("t6_e2_resp", 32'(hresp), 32'd1);
    check("t6_e2_decerr", 32'(decerr), 32'd0);
`else
    repeat (20) begin
      @(negedge HCLK);
      if (!hready && !decerr) n++;
      tick();
    end
    check("t6_stall", n, 20);
    check("t6_seen", 32'(seen), 32'd0);
    hreadyout_s[5] = 1'b1;
    @(negedge HCLK);
    check("t6_rel_ready", 32'(hready), 32'd1);
    check("t6_rel_rdata", hrdata, 32'h5555_0005);
`endif
    tick(); htrans = IDLE;
    @(negedge HCLK);
    check("t6_p0_rdata", hrdata, 32'h1111_0000);
    check("t6_p0_ready", 32'(hready), 32'd1);
    check("t6_p0_resp", 32'(hresp), 32'd0);

    tick();
    @(negedge HCLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
